// File: rtl/issue_rr_arbiter_16_pkg.sv
// Shared issue-stage definitions for the round-robin issue arbiter.
package issue_rr_arbiter_16_pkg;

  localparam int WF_ID_WIDTH   = 4;
  localparam int NUM_ISSUE_REQ = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/priority_encoder_16_to_4.sv
// 16-to-4 priority encoder: the lowest set bit wins; idx_o is 0 when nothing
// is set or the encoder is disabled, and valid_o says whether idx_o is real.
module priority_encoder_16_to_4 (
  input  logic        en_i,
  input  logic [15:0] vec_i,
  output logic [3:0]  idx_o,
  output logic        valid_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o   = 4'd0;
    valid_o = 1'b0;
    if (en_i) begin
      for (int i = 15; i >= 0; i--) begin
        if (vec_i[i]) begin
          idx_o   = i[3:0];
          valid_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/issue_rr_arbiter_16.sv
// Round-robin arbiter sharing one issue slot among 16 wavefronts. The grant is
// registered and held under a valid/ready handshake; on accept the rotation
// base moves just past the accepted wavefront, and a follow-on winner can be
// launched in the same cycle for one grant per cycle throughput.
//
// state     | meaning
// ARB_IDLE  | no grant presented
// ARB_GRANT | grant_id/grant_onehot presented and held until accept or flush
module issue_rr_arbiter_16
  import issue_rr_arbiter_16_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_ISSUE_REQ-1:0] req,
  input  logic [NUM_ISSUE_REQ-1:0] req_mask,
  input  logic                     enable,
  input  logic                     flush,
  input  logic                     grant_ready,
  output logic                     grant_valid,
  output logic [WF_ID_WIDTH-1:0]   grant_id,
  output logic [NUM_ISSUE_REQ-1:0] grant_onehot,
  output logic [WF_ID_WIDTH-1:0]   rr_ptr
);

  // Width is tied to the 16-to-4 encoder; these are not meant to be overridden.
  localparam int NUM_REQ = NUM_ISSUE_REQ;
  localparam int ID_W    = WF_ID_WIDTH;

  arb_state_e          state_q, state_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [NUM_REQ-1:0]  grant_oh_q, grant_oh_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  sel_vec;
  logic [ID_W-1:0]     ptr_after_accept;
  logic [ID_W-1:0]     sel_base;
  logic [NUM_REQ-1:0]  rot;
  logic [ID_W-1:0]     enc_idx;
  logic                enc_valid;
  logic [ID_W-1:0]     winner;
  logic [NUM_REQ-1:0]  winner_oh;

  assign elig = req & req_mask;

  // One encoder serves both launch paths: from IDLE the search starts at
  // rr_ptr; while a grant is held it is set up for the back-to-back case,
  // excluding the held bit and starting just past it. The result is only
  // consumed in GRANT when the held grant is accepted.
  assign ptr_after_accept = grant_id_q + 4'd1;
  assign sel_vec  = (state_q == ARB_GRANT) ? (elig & ~grant_oh_q) : elig;
  assign sel_base = (state_q == ARB_GRANT) ? ptr_after_accept : rr_ptr_q;

  // Rotate right so bit sel_base lands at position 0 (highest priority).
  assign rot = (sel_vec >> sel_base) | (sel_vec << (5'd16 - {1'b0, sel_base}));

  priority_encoder_16_to_4 u_prio_enc (
    .en_i    (|rot),
    .vec_i   (rot),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  // 4-bit add wraps naturally, undoing the rotation.
  assign winner    = enc_idx + sel_base;
  assign winner_oh = NUM_REQ'(1) << winner;

  // Next-state: flush wins over accept and launch; a new winner is loaded only
  // when the encoder reports a real result, so its idle output never lands.
  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    grant_oh_d = grant_oh_q;
    rr_ptr_d   = rr_ptr_q;
    if (flush) begin
      state_d    = ARB_IDLE;
      grant_oh_d = '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (enable && enc_valid) begin
            state_d    = ARB_GRANT;
            grant_id_d = winner;
            grant_oh_d = winner_oh;
          end
        end
        ARB_GRANT: begin
          if (grant_ready) begin
            rr_ptr_d = ptr_after_accept;
            if (enable && enc_valid) begin
              grant_id_d = winner;
              grant_oh_d = winner_oh;
            end else begin
              state_d    = ARB_IDLE;
              grant_oh_d = '0;
            end
          end
        end
        default: begin
          state_d    = ARB_IDLE;
          grant_oh_d = '0;
        end
      endcase
    end
  end

  // State and grant registers; reset is asynchronous and active low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      grant_id_q <= '0;
      grant_oh_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      grant_oh_q <= grant_oh_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign grant_valid  = (state_q == ARB_GRANT);
  assign grant_id     = grant_id_q;
  assign grant_onehot = grant_oh_q;
  assign rr_ptr       = rr_ptr_q;

endmodule

// File: tb/tb_issue_rr_arbiter_16.sv
// Bench for issue_rr_arbiter_16: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// search-based model of the round-robin rules.
module tb_issue_rr_arbiter_16;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] req_mask;
  logic        enable;
  logic        flush;
  logic        grant_ready;
  logic        grant_valid;
  logic [3:0]  grant_id;
  logic [15:0] grant_onehot;
  logic [3:0]  rr_ptr;

  int n_cmp = 0;
  int n_bad = 0;

  issue_rr_arbiter_16 dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_mask     (req_mask),
    .enable       (enable),
    .flush        (flush),
    .grant_ready  (grant_ready),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .grant_onehot (grant_onehot),
    .rr_ptr       (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // First eligible index searching upward from base, wrapping; -1 if none.
  function automatic int pick(input logic [15:0] v, input int base);
    for (int k = 0; k < 16; k++) begin
      if (v[(base + k) % 16]) return (base + k) % 16;
    end
    return -1;
  endfunction

  // Reference model.
  bit m_valid;
  int m_id;
  int m_ptr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_valid <= 1'b0;
      m_id    <= 0;
      m_ptr   <= 0;
    end else begin
      logic [15:0] e;
      logic [15:0] rem;
      int w;
      int np;
      e = req & req_mask;
      if (flush) begin
        m_valid <= 1'b0;
      end else if (!m_valid) begin
        w = pick(e, m_ptr);
        if (enable && w >= 0) begin
          m_valid <= 1'b1;
          m_id    <= w;
        end
      end else if (grant_ready) begin
        np  = (m_id + 1) % 16;
        m_ptr <= np;
        rem = e;
        rem[m_id] = 1'b0;
        w = pick(rem, np);
        if (enable && w >= 0) m_id <= w;
        else                  m_valid <= 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [15:0] exp_oh;
    exp_oh = m_valid ? (16'h1 << m_id) : 16'h0;
    chk("model_valid", {31'd0, grant_valid}, {31'd0, m_valid});
    chk("model_onehot", {16'd0, grant_onehot}, {16'd0, exp_oh});
    chk("model_rr_ptr", {28'd0, rr_ptr}, 32'(m_ptr));
    if (m_valid) chk("model_grant_id", {28'd0, grant_id}, 32'(m_id));
    chk("no_x_outputs", {31'd0, $isunknown({grant_valid, grant_id, grant_onehot, rr_ptr})}, 32'd0);
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; req = 16'hFFFF; req_mask = 16'hFFFF;
    enable = 1'b1; flush = 1'b0; grant_ready = 1'b0;

    // Reset with all requests pending.
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, grant_valid}, 32'd0);
    chk("rst_ptr", {28'd0, rr_ptr}, 32'd0);
    chk("rst_onehot", {16'd0, grant_onehot}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("first_valid", {31'd0, grant_valid}, 32'd1);
    chk("first_id", {28'd0, grant_id}, 32'd0);

    // Full round-robin sweep with constant ready.
    grant_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("rr_id", {28'd0, grant_id}, 32'(k % 16));
      chk("rr_ptr", {28'd0, rr_ptr}, 32'(k % 16));
    end

    // Return to idle via flush, then backpressure hold.
    flush = 1'b1; grant_ready = 1'b0; req = 16'h0000;
    @(negedge clk);
    chk("flush_idle", {31'd0, grant_valid}, 32'd0);
    flush = 1'b0; req = 16'h0090;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, grant_valid}, 32'd1);
      chk("hold_id", {28'd0, grant_id}, 32'd4);
    end
    req = 16'h0080; grant_ready = 1'b1;
    @(negedge clk);
    chk("b2b_id", {28'd0, grant_id}, 32'd7);
    chk("b2b_ptr", {28'd0, rr_ptr}, 32'd5);

    // Walk rr_ptr to 10, then masked request forces a wrapped search.
    req = 16'h0200;
    @(negedge clk);
    chk("walk_id", {28'd0, grant_id}, 32'd9);
    chk("walk_ptr", {28'd0, rr_ptr}, 32'd8);
    req = 16'h0402; req_mask = 16'hFBFF;
    @(negedge clk);
    chk("mask_wrap_id", {28'd0, grant_id}, 32'd1);
    chk("mask_wrap_ptr", {28'd0, rr_ptr}, 32'd10);

    // Flush together with ready: no pointer advance.
    req = 16'h0008; req_mask = 16'hFFFF;
    @(negedge clk);
    chk("pre_flush_id", {28'd0, grant_id}, 32'd3);
    chk("pre_flush_ptr", {28'd0, rr_ptr}, 32'd2);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_rdy_valid", {31'd0, grant_valid}, 32'd0);
    chk("flush_rdy_ptr", {28'd0, rr_ptr}, 32'd2);
    flush = 1'b0; grant_ready = 1'b0;
    @(negedge clk);
    chk("post_flush_valid", {31'd0, grant_valid}, 32'd1);
    chk("post_flush_id", {28'd0, grant_id}, 32'd3);

    // Accept with nothing left, then empty requests and enable low.
    grant_ready = 1'b1; req = 16'h0000;
    @(negedge clk);
    chk("empty_valid", {31'd0, grant_valid}, 32'd0);
    chk("empty_ptr", {28'd0, rr_ptr}, 32'd4);
    repeat (5) @(negedge clk);
    chk("empty_stay", {31'd0, grant_valid}, 32'd0);
    req = 16'hFFFF; enable = 1'b0;
    repeat (5) @(negedge clk);
    chk("disabled_stay", {31'd0, grant_valid}, 32'd0);
    enable = 1'b1; grant_ready = 1'b0;
    @(negedge clk);
    chk("enable_id", {28'd0, grant_id}, 32'd4);

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      req         = $urandom();
      if ($urandom_range(0, 1) == 0) req = req & 16'($urandom()) & 16'($urandom());
      req_mask    = ($urandom_range(0, 3) == 0) ? 16'($urandom()) : 16'hFFFF;
      enable      = ($urandom_range(0, 9) != 0);
      flush       = ($urandom_range(0, 24) == 0);
      grant_ready = ($urandom_range(0, 2) != 0);
      rst         = ($urandom_range(0, 499) != 0);
      @(negedge clk);
      rst = 1'b1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
